bin_to_bcd_converter: RTL

//   Iterative double-dabble converter: turns an unsigned binary count into eight

---
 rtl/bin_to_bcd_converter.sv | 84 ++++++++
 1 files changed

// File: rtl/bin_to_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Produces eight packed BCD digits and saturates to 9999_9999 above 99,999,999.

module bcd_nib_fix (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  // Inputs never exceed 9 in legal operation, so the 4-bit add cannot carry out.
  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

module bin_to_bcd_converter #(
  parameter int IN_WIDTH = 27
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [IN_WIDTH-1:0] bin_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [31:0]         bcd_out,
  output logic                ovf_out,
  output logic                done_out
);
  localparam int          SW   = 32 + IN_WIDTH;
  localparam logic [5:0]  LAST = 6'(IN_WIDTH - 1);
  localparam logic [31:0] MAXV = 32'd99_999_999;

  typedef enum logic {IDLE, CONV} state_e;

  state_e        state_q;
  logic [SW-1:0] sr_q, sr_fix, sr_d;
  logic [5:0]    cnt_q;
  logic          ovf_pend_q;
  logic [31:0]   bcd_q;
  logic          ovf_q, done_q;

  for (genvar g = 0; g < 8; g++) begin : g_fix
    bcd_nib_fix u_fix (
      .nib_i(sr_q[IN_WIDTH + 4*g +: 4]),
      .nib_o(sr_fix[IN_WIDTH + 4*g +: 4])
    );
  end
  assign sr_fix[IN_WIDTH-1:0] = sr_q[IN_WIDTH-1:0];
  assign sr_d = sr_fix << 1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (valid_in) begin
          sr_q       <= {32'b0, bin_in};
          cnt_q      <= '0;
          ovf_pend_q <= 32'(bin_in) > MAXV;
          state_q    <= CONV;
        end
        CONV: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 6'd1;
          // Outputs update only here, so the display never sees partial digits.
          if (cnt_q == LAST) begin
            bcd_q   <= ovf_pend_q ? 32'h9999_9999 : sr_d[SW-1 -: 32];
            ovf_q   <= ovf_pend_q;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_out = (state_q == IDLE);
  assign bcd_out   = bcd_q;
  assign ovf_out   = ovf_q;
  assign done_out  = done_q;
endmodule
